// File: rtl/depth_buffer_writer.sv
// Depth-tests shaded fragments against an internal z-buffer and emits framebuffer write strobes; clears z-buffer and framebuffer between frames.
// Latency: 2 cycles from valid_in to fb_we_out; throughput 1 fragment/cycle; a clear takes WIDTH*HEIGHT cycles.
// Backpressure: none on input; fragments arriving while busy_out=1 (clearing) are dropped.
// Ports: clk_in/rst_n_in clock and async active-low reset; valid_in,x_in,y_in,z_in,rgb_in fragment input;
//        clear_in single-cycle clear request; fb_we_out/fb_addr_out/fb_rgb_out framebuffer write port; busy_out clearing flag.
module depth_buffer_writer #(
    parameter int          WIDTH   = 320,
    parameter int          HEIGHT  = 240,
    parameter int          ADDR_W  = 17,
    parameter logic [7:0]  Z_CLEAR = 8'hFF,
    parameter logic [11:0] BG_RGB  = 12'h000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    input  logic [8:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [7:0]        z_in,
    input  logic [11:0]       rgb_in,
    input  logic              clear_in,
    output logic              fb_we_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [11:0]       fb_rgb_out,
    output logic              busy_out
);

    localparam int                NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] cnt, cnt_d;

    // S1 registers: fragment waiting for its z-buffer read data
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_addr;
    logic [7:0]        s1_z;
    logic [11:0]       s1_rgb;

    // Last z written by the compare stage; the BRAM read issued on the same
    // edge as that write returns the old value, so it is bypassed here.
    logic              fwd_vld;
    logic [ADDR_W-1:0] fwd_addr;
    logic [7:0]        fwd_z;

    logic [7:0]        zmem [NPIX];
    logic [7:0]        z_rd;

    logic              in_ok;
    logic [ADDR_W-1:0] in_addr;
    logic [7:0]        z_stored;

    logic              s1_take;
    logic              pass;
    logic              z_we;
    logic [ADDR_W-1:0] z_waddr;
    logic [7:0]        z_wdat;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [11:0]       rgb_d;

    assign in_ok    = valid_in && (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
    assign in_addr  = ADDR_W'(32'(y_in) * WIDTH + 32'(x_in));
    assign z_stored = (fwd_vld && (fwd_addr == s1_addr)) ? fwd_z : z_rd;
    assign busy_out = (state == ST_CLEAR);

    // Simple dual-port z-buffer, read-first, not reset
    always_ff @(posedge clk_in) begin
        if (z_we) begin
            zmem[z_waddr] <= z_wdat;
        end
        z_rd <= zmem[in_addr];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        s1_take    = 1'b0;
        pass       = 1'b0;
        z_we       = 1'b0;
        z_waddr    = cnt;
        z_wdat     = Z_CLEAR;
        we_d       = 1'b0;
        addr_d     = fb_addr_out;
        rgb_d      = fb_rgb_out;
        case (state)
            ST_CLEAR: begin
                z_we   = 1'b1;
                we_d   = 1'b1;
                addr_d = cnt;
                rgb_d  = BG_RGB;
                if (cnt == LAST_ADDR) begin
                    next_state = ST_RUN;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_in) begin
                    // squash both stages: nothing in flight is written
                    next_state = ST_CLEAR;
                    cnt_d      = '0;
                end else begin
                    pass    = s1_vld && (s1_z < z_stored);
                    s1_take = in_ok;
                    if (pass) begin
                        z_we    = 1'b1;
                        z_waddr = s1_addr;
                        z_wdat  = s1_z;
                        we_d    = 1'b1;
                        addr_d  = s1_addr;
                        rgb_d   = s1_rgb;
                    end
                end
            end
            default: next_state = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt         <= '0;
            s1_vld      <= 1'b0;
            s1_addr     <= '0;
            s1_z        <= '0;
            s1_rgb      <= '0;
            fwd_vld     <= 1'b0;
            fwd_addr    <= '0;
            fwd_z       <= '0;
            fb_we_out   <= 1'b0;
            fb_addr_out <= '0;
            fb_rgb_out  <= '0;
        end else begin
            cnt         <= cnt_d;
            s1_vld      <= s1_take;
            fwd_vld     <= pass;
            fb_we_out   <= we_d;
            fb_addr_out <= addr_d;
            fb_rgb_out  <= rgb_d;
            if (s1_take) begin
                s1_addr <= in_addr;
                s1_z    <= z_in;
                s1_rgb  <= rgb_in;
            end
            if (pass) begin
                fwd_addr <= s1_addr;
                fwd_z    <= s1_z;
            end
        end
    end

endmodule

// File: doc/depth_buffer_writer.md
Name: depth_buffer_writer

Overview:
Consumer of the fragment shader output stream: depth-tests each shaded fragment against an internal z-buffer and emits framebuffer write strobes for fragments that pass. It sits between fragment_shader and the framebuffer BRAM write port. It also owns z-buffer/framebuffer clearing between frames. The input has no backpressure, so the block accepts one fragment every cycle.

Parameters:
WIDTH, 320, screen width in pixels; x_in >= WIDTH is out of bounds.
HEIGHT, 240, screen height in pixels; y_in >= HEIGHT is out of bounds.
ADDR_W, 17, framebuffer/z-buffer address width; must hold WIDTH*HEIGHT-1.
Z_CLEAR, 8'hFF, z value written on clear (farthest).
BG_RGB, 12'h000, colour written to framebuffer on clear.

Ports:
clk_in  input  1  system clock; all logic on rising edge.
rst_n_in  input  1  asynchronous active-low reset.
valid_in  input  1  fragment valid, from fragment_shader valid_out.
x_in  input  9  fragment x.
y_in  input  8  fragment y.
z_in  input  8  fragment depth; smaller is nearer.
rgb_in  input  12  fragment colour.
clear_in  input  1  single-cycle request to clear z-buffer and framebuffer.
fb_we_out  output  1  framebuffer write enable.
fb_addr_out  output  ADDR_W  framebuffer write address, y*WIDTH+x.
fb_rgb_out  output  12  framebuffer write data.
busy_out  output  1  high while clearing; fragments are dropped.

Behaviour:
- Reset values: fb_we_out=0, fb_addr_out=0, fb_rgb_out=0, busy_out=1. The FSM enters CLEAR and the clear counter is 0. Pipeline valids are 0. Z-buffer contents are not reset.
- The z-buffer is internal: WIDTH*HEIGHT x 8-bit, simple dual-port, 1-cycle read latency.
- FSM states:
  - CLEAR: each cycle writes Z_CLEAR to z[cnt]. It also drives fb_we_out=1, fb_addr_out=cnt, fb_rgb_out=BG_RGB, then increments cnt. When cnt=WIDTH*HEIGHT-1 it writes that address and moves to RUN. cnt resets to 0 and busy_out deasserts on the RUN cycle. A clear takes exactly WIDTH*HEIGHT cycles.
  - RUN: clear_in=1 goes to CLEAR on the next edge. Both pipeline stages are squashed, so in-flight fragments are not written. clear_in in CLEAR is ignored; the clear does not restart.
  - Asynchronous reset mid-clear restarts the clear from address 0.
- Pipeline in RUN (fragment accepted at cycle t):
  - S1 (edge t): if valid_in and x_in<WIDTH and y_in<HEIGHT, register addr=y*WIDTH+x (ADDR_W bits), z and rgb, and issue the z-buffer read. Otherwise the fragment is silently dropped. Fragments with valid_in during CLEAR are dropped.
  - S2 (edge t+1): compare. Pass if z_frag < z_stored (strict); ties fail.
  - On pass: write z_frag to the z-buffer and register fb_we_out=1, fb_addr_out=addr, fb_rgb_out=rgb, visible on cycle t+2. On fail: fb_we_out=0.
  - Latency from valid_in to fb_we_out is 2 cycles. Throughput is 1 per cycle.
- Hazard forwarding:
  - If the S2 fragment's address equals the address written by S2 on the previous cycle, z_stored is the previously written z, not the BRAM data.
  - Fragments two or more apart see the updated BRAM value directly; the write lands before their read edge.
- fb_we_out is a single-cycle strobe per write. fb_addr_out and fb_rgb_out hold their last value when fb_we_out=0.
- No arithmetic overflow: addr < WIDTH*HEIGHT is guaranteed by the bounds check.

Test Plan:
- Reset release with WIDTH=8, HEIGHT=4 -> busy_out=1 for exactly 32 cycles; fb_we_out=1 with fb_addr_out 0..31, fb_rgb_out=BG_RGB; then busy_out=0.
- After clear, fragment (x=3,y=2,z=10,rgb=12'hAAA) at cycle t -> at t+2: fb_we_out=1, fb_addr_out=19, fb_rgb_out=12'hAAA.
- Then fragment (3,2,z=20,12'h123) -> no write. Fragment (3,2,z=10) -> no write (tie). Fragment (3,2,z=5,12'h456) -> write of 12'h456.
- Back-to-back, same pixel (1,1): z=50 then z=60 on consecutive cycles -> only the first writes, proving forwarding. Z=50 then z=40 -> both write, in order.
- Fragments with x=8 or y=4, and a fragment with valid_in during CLEAR -> no fb_we_out ever.
- clear_in one cycle after accepting a passing fragment -> that fragment is not written; a fresh 32-cycle clear follows. A second clear_in mid-clear -> clear length is unchanged.
